if_icache: RTL and testbench

- Parametrised successor to the instruction-fetch stage. Direct-mapped instruction cache with a configurable number of lines and full tag compare.
- Has explicit valid bits, a flush input, a registered memory-request FSM, and a same-cycle fill bypass.
- Sits between the PC register and decode. Requests instruction words from the memory controller on a miss.
- Optional next-line prefetch.

---
 rtl/if_pkg.sv | 26 ++
 rtl/icache_array.sv | 57 +++++
 rtl/if_icache.sv | 146 ++++++++++++++
 tb/tb_if_icache.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction-fetch cache: FSM state encoding,
// zero constants and index/tag extraction from a byte address (IF_PREFETCH_EN adds PREF use).
package if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    GAP  = 2'd2,
    PREF = 2'd3
  } state_t;

  localparam int MAX_W = 64;

  localparam logic [MAX_W-1:0] ZERO_ADDR = '0;
  localparam logic [MAX_W-1:0] ZERO_WORD = '0;

  // Word index: the IDX_W bits just above the byte offset.
  function automatic logic [MAX_W-1:0] idx_of(input logic [MAX_W-1:0] addr, input int idx_w);
    return (addr >> 2) & ((MAX_W'(1) << idx_w) - MAX_W'(1));
  endfunction

  function automatic logic [MAX_W-1:0] tag_of(input logic [MAX_W-1:0] addr, input int idx_w);
    return addr >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for a direct-mapped, one-word-per-line cache: async read with tag
// compare, one sync write port, flash clear of valid bits (second lookup port under IF_PREFETCH_EN).
module icache_array #(
  parameter int IDX_W  = 7,
  parameter int TAG_W  = 23,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [TAG_W-1:0]  rd_tag_i,
  output logic              rd_hit_o,
  output logic [DATA_W-1:0] rd_dat_o,
`ifdef IF_PREFETCH_EN
  input  logic [IDX_W-1:0]  pf_idx_i,
  input  logic [TAG_W-1:0]  pf_tag_i,
  output logic              pf_hit_o,
`endif
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [DATA_W-1:0] wr_dat_i
);

  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  // Only the valid bits need reset; tag/data are qualified by them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (clear_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_dat_i;
    end
  end

  assign rd_hit_o = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_dat_o = data_q[rd_idx_i];

`ifdef IF_PREFETCH_EN
  assign pf_hit_o = valid_q[pf_idx_i] && (tag_q[pf_idx_i] == pf_tag_i);
`endif

endmodule

// File: rtl/if_icache.sv
// Direct-mapped instruction cache for the fetch stage: 0-cycle hits, registered miss requests,
// same-cycle fill bypass, flush with discard of in-flight fills; IF_PREFETCH_EN adds next-line prefetch.
module if_icache
  import if_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 7,
  parameter int TAG_W  = ADDR_W - IDX_W - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              if_stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done
);

  state_t            state_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              discard_q;

  logic [ADDR_W-1:0] pc_word;
  logic [IDX_W-1:0]  rd_idx;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_hit;
  logic [DATA_W-1:0] rd_dat;
  logic              done_vld;
  logic              bypass;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [TAG_W-1:0]  wr_tag;

  assign pc_word = {pc_i[ADDR_W-1:2], 2'b00};
  assign rd_idx  = IDX_W'(idx_of(MAX_W'(pc_word), IDX_W));
  assign rd_tag  = TAG_W'(tag_of(MAX_W'(pc_word), IDX_W));
  assign wr_idx  = IDX_W'(idx_of(MAX_W'(mem_addr_q), IDX_W));
  assign wr_tag  = TAG_W'(tag_of(MAX_W'(mem_addr_q), IDX_W));

  // A completion pulse only counts while a request is outstanding.
  assign done_vld = mem_done && mem_req_q;
  assign bypass   = done_vld && (mem_addr_q == pc_word);
  assign wr_en    = done_vld && !flush_i && !discard_q;

`ifdef IF_PREFETCH_EN
  logic [ADDR_W-1:0] pf_word;
  logic [IDX_W-1:0]  pf_idx;
  logic [TAG_W-1:0]  pf_tag;
  logic              pf_hit;

  assign pf_word = pc_word + ADDR_W'(4);
  assign pf_idx  = IDX_W'(idx_of(MAX_W'(pf_word), IDX_W));
  assign pf_tag  = TAG_W'(tag_of(MAX_W'(pf_word), IDX_W));
`endif

  icache_array #(
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (flush_i),
    .rd_idx_i (rd_idx),
    .rd_tag_i (rd_tag),
    .rd_hit_o (rd_hit),
    .rd_dat_o (rd_dat),
`ifdef IF_PREFETCH_EN
    .pf_idx_i (pf_idx),
    .pf_tag_i (pf_tag),
    .pf_hit_o (pf_hit),
`endif
    .wr_en_i  (wr_en),
    .wr_idx_i (wr_idx),
    .wr_tag_i (wr_tag),
    .wr_dat_i (mem_rdata)
  );

  always_comb begin
    inst_o   = DATA_W'(ZERO_WORD);
    pc_o     = ADDR_W'(ZERO_ADDR);
    if_stall = 1'b1;
    if (rst) begin
      if_stall = 1'b0;
    end else if (rd_hit) begin
      inst_o   = rd_dat;
      pc_o     = pc_i;
      if_stall = 1'b0;
    end else if (bypass) begin
      inst_o   = mem_rdata;
      pc_o     = pc_i;
      if_stall = 1'b0;
    end
  end

  // GAP keeps mem_req low one cycle so the next miss sees the freshly written line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= ADDR_W'(ZERO_ADDR);
      discard_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!rd_hit) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_word;
            state_q    <= FILL;
          end
`ifdef IF_PREFETCH_EN
          else if (!pf_hit) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= pf_word;
            state_q    <= PREF;
          end
`endif
        end
        FILL, PREF: begin
          if (flush_i) begin
            discard_q <= 1'b1;
          end
          if (mem_done) begin
            mem_req_q <= 1'b0;
            state_q   <= GAP;
          end
        end
        GAP: begin
          discard_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_if_icache.sv
// Randomised and directed bench for if_icache against a line-array reference model.
module tb_if_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        flush_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        if_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_done;

  if_icache dut (
    .clk       (clk),
    .rst       (rst),
    .pc_i      (pc_i),
    .flush_i   (flush_i),
    .inst_o    (inst_o),
    .pc_o      (pc_o),
    .if_stall  (if_stall),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: 128 one-word lines plus the outstanding-request bookkeeping.
  bit          m_v [128];
  logic [22:0] m_t [128];
  logic [31:0] m_d [128];
  bit          m_req;
  bit          m_disc;
  bit          m_gap;
  logic [31:0] m_addr;
  int          cnt;
  int          lat_fix;
  bit          force_spur;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h00A0_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit m_hit(input logic [31:0] w);
    return m_v[w[8:2]] && (m_t[w[8:2]] == w[31:9]);
  endfunction

  task automatic issue(input logic [31:0] w);
    m_req  = 1'b1;
    m_addr = w;
    cnt    = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4));
  endtask

  task automatic m_reset();
    for (int i = 0; i < 128; i++) m_v[i] = 1'b0;
    m_req  = 1'b0;
    m_disc = 1'b0;
    m_gap  = 1'b0;
    m_addr = 32'h0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_stall", {31'b0, if_stall}, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_pc_o", pc_o, 32'h0);
    chk("rst_req", {31'b0, mem_req}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
  endtask

  // One clock cycle: drive at negedge, check 1ns later, then advance the model.
  task automatic cyc(input logic [31:0] pc, input bit fl);
    logic [31:0] w, rd, e_inst, e_pc;
    bit dn, h, byp;
    @(negedge clk);
    rst = 1'b0;
    w   = pc & 32'hFFFF_FFFC;
    dn  = 1'b0;
    rd  = $urandom;
    if (m_req) begin
      if (cnt <= 1) begin
        dn = 1'b1;
        rd = mem_word(m_addr);
      end else begin
        cnt--;
      end
    end else if (force_spur || $urandom_range(0, 7) == 0) begin
      dn = 1'b1;
    end
    pc_i = pc; flush_i = fl; mem_done = dn; mem_rdata = rd;
    #1;
    h      = m_hit(w);
    byp    = m_req && dn && (m_addr == w);
    e_inst = h ? m_d[w[8:2]] : (byp ? rd : 32'h0);
    e_pc   = (h || byp) ? pc : 32'h0;
    chk("stall", {31'b0, if_stall}, {31'b0, !(h || byp)});
    chk("inst", inst_o, e_inst);
    chk("pc_o", pc_o, e_pc);
    chk("req", {31'b0, mem_req}, {31'b0, m_req});
    chk("addr", mem_addr, m_addr);
    if (m_req) begin
      if (dn) begin
        if (!fl && !m_disc) begin
          m_v[m_addr[8:2]] = 1'b1;
          m_t[m_addr[8:2]] = m_addr[31:9];
          m_d[m_addr[8:2]] = rd;
        end
        m_req  = 1'b0;
        m_gap  = 1'b1;
        m_disc = 1'b0;
      end else if (fl) begin
        m_disc = 1'b1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (!h) begin
      issue(w);
    end
`ifdef IF_PREFETCH_EN
    else if (!m_hit(w + 32'd4)) begin
      issue(w + 32'd4);
    end
`endif
    if (fl) for (int i = 0; i < 128; i++) m_v[i] = 1'b0;
  endtask

  initial begin
    logic [31:0] rpc;
    rst = 1'b1; pc_i = 32'h100; flush_i = 1'b0; mem_done = 1'b0; mem_rdata = 32'h0;
    lat_fix = 3; force_spur = 1'b0;
    m_reset();
    #12;
    chk_reset_outputs();

    // Cold miss, then zero-latency hits.
    for (int k = 0; k < 8; k++) cyc(32'h100, 1'b0);
    chk("hit100", inst_o, 32'h00A0_0093);

    // Conflict on the same index, then back.
    for (int k = 0; k < 6; k++) cyc(32'h300, 1'b0);
    for (int k = 0; k < 6; k++) cyc(32'h100, 1'b0);

    // Flush while the fill is in flight.
    cyc(32'h200, 1'b0);
    cyc(32'h200, 1'b1);
    for (int k = 0; k < 8; k++) cyc(32'h200, 1'b0);

    // Redirect while a fill is outstanding.
    cyc(32'h40, 1'b0);
    for (int k = 0; k < 8; k++) cyc(32'h80, 1'b0);
    for (int k = 0; k < 2; k++) cyc(32'h40, 1'b0);

    // Asynchronous reset between edges during a fill, then a stray completion.
    cyc(32'h500, 1'b0);
    cyc(32'h500, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    m_reset();
    @(posedge clk);
    force_spur = 1'b1;
    cyc(32'h500, 1'b0);
    force_spur = 1'b0;
    for (int k = 0; k < 5; k++) cyc(32'h500, 1'b0);
    for (int k = 0; k < 2; k++) cyc(32'h100, 1'b0);

    // Address wrap at the top of memory (prefetches 0x0 when enabled).
    for (int k = 0; k < 10; k++) cyc(32'hFFFF_FFFC, 1'b0);
    for (int k = 0; k < 3; k++) cyc(32'h0, 1'b0);

    // Random traffic over a small working set.
    lat_fix = 0;
    rpc = 32'h0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFFC;
        else rpc = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      end
      cyc(rpc, $urandom_range(0, 24) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
